// File: rtl/ready_sink_checker.sv
// ready_sink_checker
//   Consumer endpoint for the ready-only handshake path. Drives ready back to
//   the producer from a programmable stall pattern, accepts one beat per cycle
//   on valid_in && ready_out, checks that beats arrive in +1 order (mod 2^DW),
//   keeps a wrapping sum and stops after BEATS accepted beats.
//
// Ports
//   sys_clk     system clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   start       one-cycle pulse, begins a run from IDLE or DONE (ignored in RUN)
//   stall_mask  bit p set -> ready low in pattern phase p; sampled at start
//   valid_in    producer has a beat on data_in
//   data_in     producer data
//   ready_out   consumer can accept this cycle (registered terms only)
//   beat_cnt    beats accepted in the current/last run
//   sum_out     wrapping sum of accepted data
//   last_data   most recently accepted data
//   done        run complete, held until the next start
//   err_order   sticky order error for the current/last run
module ready_sink_checker #(
    parameter int unsigned DW    = 3,
    parameter int unsigned PAT_W = 8,
    parameter int unsigned BEATS = 16,
    parameter int unsigned SUM_W = 8,
    localparam int unsigned CNT_W = $clog2(BEATS + 1),
    localparam int unsigned PH_W  = (PAT_W > 1) ? $clog2(PAT_W) : 1
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PAT_W-1:0] stall_mask,
    input  logic             valid_in,
    input  logic [DW-1:0]    data_in,
    output logic             ready_out,
    output logic [CNT_W-1:0] beat_cnt,
    output logic [SUM_W-1:0] sum_out,
    output logic [DW-1:0]    last_data,
    output logic             done,
    output logic             err_order
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [PAT_W-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [DW-1:0]      last_q, last_d;
    logic               err_q, err_d;
    logic               first_q, first_d;

    logic               accept;
    logic [DW-1:0]      exp_next;

    // Ready comes purely from registers so there is no input-to-ready path.
    assign ready_out = (state_q == StRun) && !mask_q[phase_q];
    assign accept    = valid_in && ready_out;
    assign exp_next  = last_q + DW'(1);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        last_d  = last_q;
        err_d   = err_q;
        first_d = first_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    mask_d  = stall_mask;
                    phase_d = '0;
                    cnt_d   = '0;
                    sum_d   = '0;
                    last_d  = '0;
                    err_d   = 1'b0;
                    first_d = 1'b1;
                end
            end
            StRun: begin
                // Pattern phase runs free of valid_in.
                phase_d = (phase_q == PH_W'(PAT_W - 1)) ? '0 : phase_q + PH_W'(1);
                if (accept) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    sum_d   = sum_q + SUM_W'(data_in);
                    last_d  = data_in;
                    first_d = 1'b0;
                    if (!first_q && (data_in != exp_next)) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q == CNT_W'(BEATS - 1)) begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            phase_q <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            last_q  <= '0;
            err_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            last_q  <= last_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    assign beat_cnt  = cnt_q;
    assign sum_out   = sum_q;
    assign last_data = last_q;
    assign done      = (state_q == StDone);
    assign err_order = err_q;

endmodule

// File: tb/tb_ready_sink_checker.sv
// Testbench for ready_sink_checker: a queue-based reference model of accepted
// beats, a per-cycle compare process, and directed runs with literal results.
module tb_ready_sink_checker;

    localparam int DW    = 3;
    localparam int PAT_W = 8;
    localparam int BEATS = 16;
    localparam int SUM_W = 8;
    localparam int CNT_W = $clog2(BEATS + 1);

    logic             sys_clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [PAT_W-1:0] stall_mask;
    logic             valid_in;
    logic [DW-1:0]    data_in;
    logic             ready_out;
    logic [CNT_W-1:0] beat_cnt;
    logic [SUM_W-1:0] sum_out;
    logic [DW-1:0]    last_data;
    logic             done;
    logic             err_order;

    int checks = 0;
    int errors = 0;

    ready_sink_checker #(
        .DW    (DW),
        .PAT_W (PAT_W),
        .BEATS (BEATS),
        .SUM_W (SUM_W)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .start      (start),
        .stall_mask (stall_mask),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .ready_out  (ready_out),
        .beat_cnt   (beat_cnt),
        .sum_out    (sum_out),
        .last_data  (last_data),
        .done       (done),
        .err_order  (err_order)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the run is the list of accepted beats.
    bit               m_running;
    bit               m_done;
    logic [PAT_W-1:0] m_mask;
    int               m_cycles;
    int               m_q[$];

    function automatic bit m_ready();
        return m_running && !m_mask[m_cycles % PAT_W];
    endfunction

    function automatic int m_sum();
        int s = 0;
        foreach (m_q[i]) s += m_q[i];
        return s % (1 << SUM_W);
    endfunction

    function automatic int m_last();
        return (m_q.size() > 0) ? m_q[m_q.size() - 1] : 0;
    endfunction

    function automatic bit m_err();
        for (int i = 1; i < m_q.size(); i++) begin
            if (m_q[i] != (m_q[i - 1] + 1) % (1 << DW)) return 1'b1;
        end
        return 1'b0;
    endfunction

    initial begin
        forever begin
            @(posedge sys_clk or negedge rst_n);
            if (!rst_n) begin
                m_running = 1'b0;
                m_done    = 1'b0;
                m_mask    = '0;
                m_cycles  = 0;
                m_q.delete();
            end else if (m_running) begin
                if (valid_in && m_ready()) m_q.push_back(int'(data_in));
                m_cycles++;
                if (m_q.size() == BEATS) begin
                    m_running = 1'b0;
                    m_done    = 1'b1;
                end
            end else if (start) begin
                m_running = 1'b1;
                m_done    = 1'b0;
                m_mask    = stall_mask;
                m_cycles  = 0;
                m_q.delete();
            end
        end
    end

    initial begin
        forever begin
            @(negedge sys_clk);
            check("ready_out", ready_out, m_ready());
            check("beat_cnt", beat_cnt, m_q.size());
            check("sum_out", sum_out, m_sum());
            check("last_data", last_data, m_last());
            check("done", done, m_done);
            check("err_order", err_order, m_err());
        end
    end

    function automatic logic [DW-1:0] data_at(input int i, input bit skip);
        int v;
        v = (skip && i >= 3) ? i + 1 : i;
        return DW'(v % (1 << DW));
    endfunction

    // Start a run and act as a holding producer until done or the budget ends.
    task automatic do_run(input logic [PAT_W-1:0] mask, input bit skip, input bit toggle,
                          input int pulse_at, input int rst_after, input int budget,
                          output int run_cycles, output bit saw_done);
        int idx;
        int cyc;
        bit r;
        idx      = 0;
        cyc      = 0;
        saw_done = 1'b0;
        @(posedge sys_clk); #1;
        stall_mask = mask;
        start      = 1'b1;
        valid_in   = 1'b0;
        @(posedge sys_clk); #1;
        start      = 1'b0;
        stall_mask = '0;
        while (cyc < budget) begin
            valid_in = toggle ? (cyc % 2 == 0) : 1'b1;
            data_in  = data_at(idx, skip);
            start    = (cyc == pulse_at);
            // A start in RUN must not reload the mask either.
            stall_mask = (cyc == pulse_at) ? '1 : '0;
            @(negedge sys_clk);
            if (cyc == 0) begin
                check("start_beat_cnt", beat_cnt, 0);
                check("start_sum", sum_out, 0);
                check("start_done", done, 0);
                check("start_err", err_order, 0);
            end
            if (done) begin
                saw_done = 1'b1;
                break;
            end
            r = ready_out;
            @(posedge sys_clk); #1;
            if (valid_in && r) idx++;
            cyc++;
            if (rst_after > 0 && idx == rst_after) begin
                rst_n = 1'b0;
                break;
            end
        end
        start      = 1'b0;
        stall_mask = '0;
        valid_in   = 1'b0;
        run_cycles = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int rc;
        bit sd;
        rst_n      = 1'b0;
        start      = 1'b0;
        stall_mask = '0;
        valid_in   = 1'b0;
        data_in    = '0;
        repeat (2) @(negedge sys_clk);
        check("reset_ready", ready_out, 0);
        check("reset_beat_cnt", beat_cnt, 0);
        check("reset_done", done, 0);
        #1 rst_n = 1'b1;

        // 1: no stalls, 16 RUN cycles, done visible on the 17th.
        do_run(8'h00, 1'b0, 1'b0, -1, 0, 40, rc, sd);
        check("t1_done_seen", sd, 1);
        check("t1_run_cycles", rc, 16);
        check("t1_beat_cnt", beat_cnt, 16);
        check("t1_sum", sum_out, 56);
        check("t1_last", last_data, 7);
        check("t1_err", err_order, 0);

        // 2: phases 0 and 2 stalled, 22 RUN cycles.
        do_run(8'h05, 1'b0, 1'b0, -1, 0, 60, rc, sd);
        check("t2_done_seen", sd, 1);
        check("t2_run_cycles", rc, 22);
        check("t2_sum", sum_out, 56);
        check("t2_err", err_order, 0);

        // 3: 3 skipped; sum 0+1+2+4+5+6+7 + 0..7 + 0 = 53.
        do_run(8'h00, 1'b1, 1'b0, -1, 0, 40, rc, sd);
        check("t3_done_seen", sd, 1);
        check("t3_err", err_order, 1);
        check("t3_sum", sum_out, 53);
        check("t3_last", last_data, 0);

        // 4: valid every other cycle, 31 RUN cycles, done on the 32nd.
        do_run(8'h00, 1'b0, 1'b1, -1, 0, 80, rc, sd);
        check("t4_done_seen", sd, 1);
        check("t4_run_cycles", rc, 31);
        check("t4_beat_cnt", beat_cnt, 16);
        check("t4_sum", sum_out, 56);

        // 6: start during RUN ignored; the next run's restart is checked at its first cycle.
        do_run(8'h00, 1'b0, 1'b0, 3, 0, 40, rc, sd);
        check("t6_done_seen", sd, 1);
        check("t6_run_cycles", rc, 16);
        check("t6_beat_cnt", beat_cnt, 16);
        check("t6_sum", sum_out, 56);

        // 5: reset after 5 beats clears everything at once.
        do_run(8'h00, 1'b0, 1'b0, -1, 5, 40, rc, sd);
        #1;
        check("t5_abort_no_done", sd, 0);
        check("t5_rst_ready", ready_out, 0);
        check("t5_rst_beat_cnt", beat_cnt, 0);
        check("t5_rst_sum", sum_out, 0);
        check("t5_rst_last", last_data, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_err", err_order, 0);
        @(negedge sys_clk);
        #1 rst_n = 1'b1;
        do_run(8'h00, 1'b0, 1'b0, -1, 0, 40, rc, sd);
        check("t5_done_seen", sd, 1);
        check("t5_run_cycles", rc, 16);
        check("t5_sum", sum_out, 56);
        check("t5_err", err_order, 0);

        // All-ones mask: ready never asserts, run stalls until reset.
        do_run(8'hFF, 1'b0, 1'b0, -1, 0, 20, rc, sd);
        check("stall_no_done", sd, 0);
        check("stall_run_cycles", rc, 20);
        check("stall_beat_cnt", beat_cnt, 0);
        @(posedge sys_clk); #1;
        rst_n = 1'b0;
        @(negedge sys_clk);
        check("stall_rst_ready", ready_out, 0);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        check("final_idle_ready", ready_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
